// File: rtl/pc_sequencer.sv
// pc_sequencer: registered MIPS program counter with stall, branch, jump, jr and trap redirection.
// Optional return-address stack for jr $ra prediction is enabled by defining PC_RAS_EN.
module pc_sequencer #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] TRAP_VEC = ADDR_W'(32'h8000_0180),
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic [31:0]       instr,
  input  logic              branch,
  input  logic              bne,
  input  logic              zero,
  input  logic              jump,
  input  logic              link,
  input  logic              jr,
  input  logic              ret,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic              trap,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              redirect,
  output logic              misalign,
  output logic              ras_ovf,
  output logic              ras_unf
);
  logic [ADDR_W-1:0] pc_q, pc_d, br_tgt, j_tgt, reg_tgt;
  logic redirect_q, redirect_d, misalign_q, misalign_d;
  logic taken, hold, jr_sel, jal_sel, mis, unused_ok;
  assign pc_plus4 = pc_q + ADDR_W'(4);
  assign taken = branch & (zero ^ bne);
  assign br_tgt = pc_plus4 + {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};
  assign j_tgt = {pc_plus4[ADDR_W-1:28], instr[25:0], 2'b00};
  assign hold = stall & ~trap;
  assign jr_sel = ~stall & ~trap & jr;
  assign jal_sel = ~stall & ~trap & ~jr & jump & link;
  assign mis = jr_sel & (reg_tgt[1:0] != 2'b00);
  assign unused_ok = ^{instr[31:26], ret, jal_sel};
  always_comb begin
    pc_d = trap ? TRAP_VEC : stall ? pc_q : jr ? (mis ? TRAP_VEC : reg_tgt) :
           jump ? j_tgt : taken ? br_tgt : pc_plus4;
    redirect_d = hold ? redirect_q : (trap | jr | jump | taken);
    misalign_d = hold ? misalign_q : mis;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc_q <= RESET_VEC;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      redirect_q <= redirect_d;
      misalign_q <= misalign_d;
    end
  assign pc = pc_q;
  assign redirect = redirect_q;
  assign misalign = misalign_q;
`ifdef PC_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [ADDR_W-1:0] ras_d [RAS_DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, unf_q, unf_d, full, use_ras, push, pop;
  assign full = cnt_q == CW'(RAS_DEPTH);
  assign use_ras = ret & (cnt_q != '0);
  assign reg_tgt = use_ras ? ras_q[ptr_q] : jr_target;
  assign push = jal_sel;
  assign pop = jr_sel & use_ras;
  // ptr_q addresses the top entry; a push on a full stack wraps onto the oldest one
  always_comb begin
    ras_d = ras_q;
    if (push) ras_d[ptr_q + PW'(1)] = pc_plus4;
    ptr_d = push ? ptr_q + PW'(1) : pop ? ptr_q - PW'(1) : ptr_q;
    cnt_d = push ? (full ? cnt_q : cnt_q + CW'(1)) : pop ? cnt_q - CW'(1) : cnt_q;
    ovf_d = hold ? ovf_q : push & full;
    unf_d = hold ? unf_q : jr_sel & ret & (cnt_q == '0);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ras_q <= ras_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  assign ras_ovf = ovf_q;
  assign ras_unf = unf_q;
`else
  localparam int unused_depth = RAS_DEPTH;
  assign reg_tgt = jr_target;
  assign ras_ovf = 1'b0;
  assign ras_unf = 1'b0;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scoreboard bench for pc_sequencer; RAS vectors run when PC_RAS_EN is defined.
module tb_pc_sequencer;
  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [3:0]  flags;
  } exp_t;
  localparam logic [8:0] S = 9'h100, TR = 9'h080, JR = 9'h040, RT = 9'h020, J = 9'h010,
                         L = 9'h008, B = 9'h004, BN = 9'h002, Z = 9'h001;
  logic clk = 1'b0, rst_n = 1'b0;
  logic stall = 0, branch = 0, bne = 0, zero = 0, jump = 0, link = 0, jr = 0, ret = 0, trap = 0;
  logic [31:0] instr = '0, jr_target = '0, pc, pc_plus4;
  logic redirect, misalign, ras_ovf, ras_unf;
  exp_t sb[$];
  int checks = 0, passed = 0;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .instr(instr), .branch(branch), .bne(bne),
    .zero(zero), .jump(jump), .link(link), .jr(jr), .ret(ret), .jr_target(jr_target),
    .trap(trap), .pc(pc), .pc_plus4(pc_plus4), .redirect(redirect), .misalign(misalign),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  // flags = {redirect, misalign, ras_ovf, ras_unf}
  task automatic go(input string n, input logic [8:0] ctl, input logic [31:0] ins,
                    input logic [31:0] jt, input logic [31:0] epc, input logic [3:0] ef);
    exp_t e;
    {stall, trap, jr, ret, jump, link, branch, bne, zero} = ctl;
    instr = ins;
    jr_target = jt;
    @(posedge clk);
    e.name = n;
    e.pc = epc;
    e.flags = ef;
    sb.push_back(e);
    #1;
  endtask

  always @(negedge clk)
    if (rst_n && sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.name, ".pc"}, pc, e.pc);
      chk({e.name, ".pc4"}, pc_plus4, e.pc + 32'd4);
      chk({e.name, ".flags"}, {28'd0, redirect, misalign, ras_ovf, ras_unf}, {28'd0, e.flags});
    end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    #3;
    chk("reset.pc", pc, 32'h0);
    chk("reset.flags", {28'd0, redirect, misalign, ras_ovf, ras_unf}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    go("idle0", 9'h0, 0, 0, 32'h4, 4'b0000);
    go("idle1", 9'h0, 0, 0, 32'h8, 4'b0000);
    go("idle2", 9'h0, 0, 0, 32'hC, 4'b0000);
    go("jr100", JR, 0, 32'h100, 32'h100, 4'b1000);
    go("bne_tk", B | BN, 32'hFFFC, 0, 32'hF4, 4'b1000);
    go("jr100b", JR, 0, 32'h100, 32'h100, 4'b1000);
    go("bne_nt", B | BN | Z, 32'hFFFC, 0, 32'h104, 4'b0000);
    go("beq_tk", B | Z, 32'h3, 0, 32'h114, 4'b1000);
    go("jr_hi", JR, 0, 32'h1000_0010, 32'h1000_0010, 4'b1000);
    go("jump", J, 32'h40, 0, 32'h1000_0100, 4'b1000);
    for (int i = 0; i < 3; i++) go("stall", S | J, 32'h40, 0, 32'h1000_0100, 4'b1000);
    go("trap_st", S | TR, 0, 0, 32'h8000_0180, 4'b1000);
    go("after_tr", 9'h0, 0, 0, 32'h8000_0184, 4'b0000);
    go("mis202", JR, 0, 32'h202, 32'h8000_0180, 4'b1100);
    go("mis_clr", 9'h0, 0, 0, 32'h8000_0184, 4'b0000);
    go("mis201", JR, 0, 32'h201, 32'h8000_0180, 4'b1100);
    go("mis_hold", S, 0, 0, 32'h8000_0180, 4'b1100);
    go("mis_clr2", 9'h0, 0, 0, 32'h8000_0184, 4'b0000);
    go("prio_jr", JR | J | B | Z, 32'h40, 32'h400, 32'h400, 4'b1000);
    go("prio_tr", TR | JR, 0, 32'h500, 32'h8000_0180, 4'b1000);
    go("jr_top", JR, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 4'b1000);
    go("wrap", 9'h0, 0, 0, 32'h0, 4'b0000);
    go("jr_top2", JR, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 4'b1000);
    go("jwrap", J, 32'h1, 0, 32'h4, 4'b1000);
`ifdef PC_RAS_EN
    go("jr10", JR, 0, 32'h10, 32'h10, 4'b1000);
    go("jal1", J | L, 32'h8, 0, 32'h20, 4'b1000);
    go("jal2", J | L, 32'hC, 0, 32'h30, 4'b1000);
    go("jal3", J | L, 32'h10, 0, 32'h40, 4'b1000);
    go("jal4", J | L, 32'h14, 0, 32'h50, 4'b1000);
    go("jal5_ovf", J | L, 32'h18, 0, 32'h60, 4'b1010);
    go("ret1", JR | RT, 0, 0, 32'h54, 4'b1000);
    go("ret2", JR | RT, 0, 0, 32'h44, 4'b1000);
    go("ret3", JR | RT, 0, 0, 32'h34, 4'b1000);
    go("ret4", JR | RT, 0, 0, 32'h24, 4'b1000);
    go("ret5_unf", JR | RT, 0, 0, 32'h0, 4'b1001);
    go("ras_idle", 9'h0, 0, 0, 32'h4, 4'b0000);
`else
    go("jal_norас", J | L, 32'h8, 0, 32'h20, 4'b1000);
    go("ret_ign", JR | RT, 0, 32'h300, 32'h300, 4'b1000);
`endif
    {stall, trap, jr, ret, jump, link, branch, bne, zero} = '0;
    @(negedge clk);
    #1;
    chk("sb_drain", sb.size(), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst.pc", pc, 32'h0);
    chk("async_rst.flags", {28'd0, redirect, misalign, ras_ovf, ras_unf}, 32'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
